rv32i_insn_sequencer: RTL and testbench

Sequencing controller for the RV32I (non-SYSTEM) instruction validity checker in the coverage test harness. A 32-bit LFSR generates candidate instruction words, and the checker qualifies each one. Accepted words go out on a valid/ready stream to the coverage bench. The block counts emitted and rejected candidates, records which opcode classes were hit, and stops after a programmed number of emissions or a run of consecutive rejects.

---
 rtl/rv32i_cov_pkg.sv | 69 ++++++
 rtl/rv32i_insn_sequencer_checker.sv | 47 ++++
 rtl/rv32i_insn_sequencer.sv | 134 +++++++++++++
 tb/tb_rv32i_insn_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_cov_pkg.sv
// Shared types and helpers for the RV32I coverage instruction sequencer.
// Opcode classes, FSM states, LFSR step and saturating counter increment.
package rv32i_cov_pkg;

  typedef enum logic [3:0] {
    LUI    = 4'd0,
    AUIPC  = 4'd1,
    JAL    = 4'd2,
    JALR   = 4'd3,
    BRANCH = 4'd4,
    LOAD   = 4'd5,
    STORE  = 4'd6,
    OP_IMM = 4'd7,
    OP     = 4'd8
  } insn_class_e;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    OFFER,
    DONE
  } seq_state_e;

  localparam int NUM_CLASSES = 9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(
    input logic [31:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic insn_class_e opc_class(
    input logic [6:0] opc
  );
    insn_class_e c;
    c = LUI;
    case (opc)
      OPC_AUIPC:  c = AUIPC;
      OPC_JAL:    c = JAL;
      OPC_JALR:   c = JALR;
      OPC_BRANCH: c = BRANCH;
      OPC_LOAD:   c = LOAD;
      OPC_STORE:  c = STORE;
      OPC_OP_IMM: c = OP_IMM;
      OPC_OP:     c = OP;
      default:    c = LUI;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rv32i_insn_sequencer_checker.sv
// RV32I (non-SYSTEM) instruction validity checker.
// Purely combinational; unknown opcodes, FENCE and SYSTEM are rejected.
module rv32i_insn_sequencer_checker
  import rv32i_cov_pkg::*;
(
  input  logic [31:0] insn,
  output logic        valid
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign f3 = insn[14:12];
  assign f7 = insn[31:25];
  assign unused_bits = ^{insn[24:15], insn[11:7]};

  // opcode-specific funct3/funct7 legality
  always_comb begin
    valid = 1'b0;
    case (insn[6:0])
      OPC_LUI,
      OPC_AUIPC,
      OPC_JAL:    valid = 1'b1;
      OPC_JALR:   valid = (f3 == 3'b000);
      OPC_BRANCH: valid = (f3 != 3'b010) &&
                          (f3 != 3'b011);
      OPC_LOAD:   valid = f3 inside {3'd0, 3'd1, 3'd2,
                                     3'd4, 3'd5};
      OPC_STORE:  valid = (f3 <= 3'd2);
      OPC_OP_IMM: begin
        if (f3 == 3'b001)
          valid = (f7 == 7'h00);
        else if (f3 == 3'b101)
          valid = (f7 == 7'h00) || (f7 == 7'h20);
        else
          valid = 1'b1;
      end
      OPC_OP:     valid = (f7 == 7'h00) ||
                          ((f7 == 7'h20) &&
                           ((f3 == 3'b000) ||
                            (f3 == 3'b101)));
      default:    valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv32i_insn_sequencer.sv
// LFSR-driven RV32I candidate generator feeding a valid/ready stream.
// Counts emissions and rejects, tracks class coverage, stops on limits.
module rv32i_insn_sequencer
  import rv32i_cov_pkg::*;
#(
  parameter int          NUM_INSNS  = 256,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter int          MAX_REJECT = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_insn,
  output logic [3:0]  out_class,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] emit_count,
  output logic [15:0] reject_count,
  output logic [8:0]  class_hit
);

  localparam logic [31:0] SEED_LD  =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] EMIT_LIM = 16'(NUM_INSNS);
  localparam logic [15:0] REJ_LIM  = 16'(MAX_REJECT);

  seq_state_e  state_q, state_d;
  insn_class_e cls_q;
  logic [31:0] lfsr_q, lfsr_nx, cand, insn_q;
  logic        cand_ok, can_start, hs, hit_lim;
  logic [15:0] emit_q, rej_q, run_q;
  logic [15:0] emit_nx, run_nx;
  logic [8:0]  hit_q;
  logic        err_q;

  assign lfsr_nx   = lfsr_next(lfsr_q);
  assign cand      = lfsr_nx | 32'h3;
  assign can_start = start & ~abort &
                     ((state_q == IDLE) | (state_q == DONE));
  assign hs        = (state_q == OFFER) & out_ready;
  assign emit_nx   = sat_inc(emit_q);
  assign run_nx    = sat_inc(run_q);
  assign hit_lim   = (run_nx == REJ_LIM);

  rv32i_insn_sequencer_checker u_chk (
    .insn  (cand),
    .valid (cand_ok)
  );

  // state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE,
        DONE: if (start) state_d = GEN;
        GEN: begin
          if (cand_ok)      state_d = OFFER;
          else if (hit_lim) state_d = DONE;
        end
        OFFER: begin
          if (out_ready)
            state_d = (emit_nx == EMIT_LIM) ? DONE : GEN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // run datapath: LFSR, offered word, counters, coverage
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= SEED_LD;
      insn_q <= 32'h0;
      cls_q  <= LUI;
      emit_q <= 16'h0;
      rej_q  <= 16'h0;
      run_q  <= 16'h0;
      hit_q  <= 9'h0;
      err_q  <= 1'b0;
    end else if (can_start) begin
      lfsr_q <= SEED_LD;
      emit_q <= 16'h0;
      rej_q  <= 16'h0;
      run_q  <= 16'h0;
      hit_q  <= 9'h0;
      err_q  <= 1'b0;
    end else begin
      if (!abort && (state_q == GEN)) begin
        lfsr_q <= lfsr_nx;
        if (cand_ok) begin
          insn_q <= cand;
          cls_q  <= opc_class(cand[6:0]);
          run_q  <= 16'h0;
        end else begin
          rej_q <= sat_inc(rej_q);
          run_q <= run_nx;
          if (hit_lim) err_q <= 1'b1;
        end
      end
      if (hs) begin
        emit_q <= emit_nx;
        hit_q  <= hit_q | (9'd1 << cls_q);
      end
    end
  end

  // state-decoded outputs
  always_comb begin
    out_valid = (state_q == OFFER);
    busy      = (state_q == GEN) | (state_q == OFFER);
    done      = (state_q == DONE);
  end

  assign out_insn     = insn_q;
  assign out_class    = cls_q;
  assign error        = err_q;
  assign emit_count   = emit_q;
  assign reject_count = rej_q;
  assign class_hit    = hit_q;

endmodule

// File: tb/tb_rv32i_insn_sequencer.sv
// Bench for rv32i_insn_sequencer: three parameterisations, directed
// literal scenarios, then random start/abort/ready against a model.
module tb_rv32i_insn_sequencer;

  localparam logic [2:0][31:0] SEEDP =
    {32'h0000_0000, 32'h0000_00FE, 32'h0000_0001};
  localparam logic [2:0][15:0] NUMP = {16'd200, 16'd1, 16'd4};
  localparam logic [2:0][15:0] MAXP = {16'd6, 16'd1, 16'd8};

  localparam int P_IDLE  = 0;
  localparam int P_GEN   = 1;
  localparam int P_OFFER = 2;
  localparam int P_DONE  = 3;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;

  logic [2:0]       ov, bz, dn, er;
  logic [2:0][31:0] oi;
  logic [2:0][3:0]  oc;
  logic [2:0][15:0] ec, rc;
  logic [2:0][8:0]  ch;

  int checks = 0;
  int errors = 0;

  int          ph [3];
  logic [31:0] mlf [3];
  logic [31:0] mins [3];
  int          mcls [3];
  int          memit [3];
  int          mrej [3];
  int          mrun [3];
  logic [8:0]  mhit [3];
  bit          merr [3];

  logic [31:0] wq [$];
  logic [31:0] exp_w [4];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32i_insn_sequencer #(
      .NUM_INSNS  (int'(NUMP[g])),
      .SEED       (SEEDP[g]),
      .MAX_REJECT (int'(MAXP[g]))
    ) u_dut (
      .clock        (clock),
      .resetn       (resetn),
      .start        (start),
      .abort        (abort),
      .out_valid    (ov[g]),
      .out_ready    (out_ready),
      .out_insn     (oi[g]),
      .out_class    (oc[g]),
      .busy         (bz[g]),
      .done         (dn[g]),
      .error        (er[g]),
      .emit_count   (ec[g]),
      .reject_count (rc[g]),
      .class_hit    (ch[g])
    );
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int class_of(input logic [6:0] o);
    logic [6:0] opcs [9];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
             7'h03, 7'h23, 7'h13, 7'h33};
    for (int i = 0; i < 9; i++)
      if (opcs[i] == o) return i;
    return -1;
  endfunction

  function automatic bit legal(input logic [31:0] w);
    logic [7:0] ok3;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (class_of(w[6:0]))
      0, 1, 2: return 1'b1;
      3: return f3 == 3'd0;
      4: begin ok3 = 8'b1111_0011; return ok3[f3]; end
      5: begin ok3 = 8'b0011_0111; return ok3[f3]; end
      6: begin ok3 = 8'b0000_0111; return ok3[f3]; end
      7: begin
        if (f3 == 3'd1) return f7 == 7'h00;
        if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
        return 1'b1;
      end
      8: return f7 == 7'h00 ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_clear(input int k);
    mlf[k] = (SEEDP[k] == 32'h0) ? 32'h1 : SEEDP[k];
    memit[k] = 0;
    mrej[k] = 0;
    mrun[k] = 0;
    mhit[k] = '0;
    merr[k] = 1'b0;
  endtask

  task automatic model_reset(input int k);
    model_clear(k);
    ph[k] = P_IDLE;
    mins[k] = 32'h0;
    mcls[k] = 0;
  endtask

  task automatic model_emit(input int k);
    memit[k] = sat(memit[k] + 1);
    mhit[k][mcls[k]] = 1'b1;
  endtask

  task automatic model_step(input int k, input bit st,
                            input bit ab, input bit rdy);
    logic [31:0] w;
    if (ab) begin
      if (ph[k] == P_OFFER && rdy) model_emit(k);
      ph[k] = P_IDLE;
      return;
    end
    case (ph[k])
      P_IDLE, P_DONE: begin
        if (st) begin
          model_clear(k);
          ph[k] = P_GEN;
        end
      end
      P_GEN: begin
        if (mlf[k][0]) mlf[k] = (mlf[k] >> 1) ^ 32'h8020_0003;
        else           mlf[k] = mlf[k] >> 1;
        w = mlf[k] | 32'h3;
        if (legal(w)) begin
          mins[k] = w;
          mcls[k] = class_of(w[6:0]);
          mrun[k] = 0;
          ph[k] = P_OFFER;
        end else begin
          mrej[k] = sat(mrej[k] + 1);
          mrun[k]++;
          if (mrun[k] == int'(MAXP[k])) begin
            merr[k] = 1'b1;
            ph[k] = P_DONE;
          end
        end
      end
      default: begin
        if (rdy) begin
          model_emit(k);
          ph[k] = (memit[k] == int'(NUMP[k])) ? P_DONE : P_GEN;
        end
      end
    endcase
  endtask

  task automatic compare(input int k);
    chk($sformatf("dut%0d out_valid", k), ov[k], ph[k] == P_OFFER);
    chk($sformatf("dut%0d busy", k), bz[k],
        ph[k] == P_GEN || ph[k] == P_OFFER);
    chk($sformatf("dut%0d done", k), dn[k], ph[k] == P_DONE);
    chk($sformatf("dut%0d out_insn", k), oi[k], mins[k]);
    chk($sformatf("dut%0d out_class", k), oc[k], mcls[k]);
    chk($sformatf("dut%0d emit_count", k), ec[k], memit[k]);
    chk($sformatf("dut%0d reject_count", k), rc[k], mrej[k]);
    chk($sformatf("dut%0d class_hit", k), ch[k], mhit[k]);
    chk($sformatf("dut%0d error", k), er[k], merr[k]);
  endtask

  task automatic cycle(input bit st, input bit ab, input bit rdy);
    @(negedge clock);
    start = st;
    abort = ab;
    out_ready = rdy;
    @(posedge clock);
    for (int k = 0; k < 3; k++) model_step(k, st, ab, rdy);
    #2;
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d out_valid", k), ov[k], 0);
      chk($sformatf("rst%0d out_insn", k), oi[k], 0);
      chk($sformatf("rst%0d out_class", k), oc[k], 0);
      chk($sformatf("rst%0d busy", k), bz[k], 0);
      chk($sformatf("rst%0d done", k), dn[k], 0);
      chk($sformatf("rst%0d error", k), er[k], 0);
      chk($sformatf("rst%0d emit", k), ec[k], 0);
      chk($sformatf("rst%0d reject", k), rc[k], 0);
      chk($sformatf("rst%0d class_hit", k), ch[k], 0);
      model_reset(k);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic run_collect();
    int n;
    wq.delete();
    n = 0;
    while (!dn[0] && n < 40) begin
      cycle(1'b0, 1'b0, 1'b1);
      if (ov[0]) wq.push_back(oi[0]);
      n++;
    end
    chk("run0 reached done", dn[0], 1);
  endtask

  task automatic check_words();
    chk("dut0 word count", wq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < wq.size())
        chk($sformatf("dut0 word%0d", i), wq[i], exp_w[i]);
  endtask

  task automatic check_run_end();
    chk("dut0 end emit", ec[0], 4);
    chk("dut0 end error", er[0], 0);
    chk("dut0 end busy", bz[0], 0);
    chk("dut0 end class_hit", ch[0], 9'h020);
    chk("dut1 error", er[1], 1);
    chk("dut1 done", dn[1], 1);
    chk("dut1 reject", rc[1], 1);
    chk("dut1 emit", ec[1], 0);
  endtask

  initial begin
    exp_w = '{32'h8020_0003, 32'hC030_0003,
              32'h6018_0003, 32'hB02C_0003};
    for (int k = 0; k < 3; k++) model_reset(k);
    do_reset();

    cycle(1'b1, 1'b0, 1'b1);
    chk("dut0 busy after start", bz[0], 1);
    run_collect();
    check_words();
    chk("dut0 first class", 5, class_of(exp_w[0][6:0]));
    check_run_end();

    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    chk("dut0 offer valid", ov[0], 1);
    chk("dut0 offer word", oi[0], 32'h8020_0003);
    chk("dut0 offer class", oc[0], 5);
    repeat (10) cycle(1'b0, 1'b0, 1'b0);
    chk("stall valid", ov[0], 1);
    chk("stall word", oi[0], 32'h8020_0003);
    chk("stall emit", ec[0], 0);
    cycle(1'b0, 1'b0, 1'b1);
    chk("stall release emit", ec[0], 1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("post stall word", oi[0], 32'hC030_0003);
    cycle(1'b0, 1'b1, 1'b1);
    chk("abort hs emit", ec[0], 2);
    chk("abort valid", ov[0], 0);
    chk("abort busy", bz[0], 0);
    chk("abort done", dn[0], 0);
    cycle(1'b1, 1'b0, 1'b1);
    chk("restart emit", ec[0], 0);
    chk("restart class_hit", ch[0], 0);
    run_collect();
    check_words();
    check_run_end();

    cycle(1'b1, 1'b0, 1'b1);
    do_reset();
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    run_collect();
    chk("busy start words", wq.size(), 3);
    chk("busy start emit", ec[0], 4);
    chk("busy start last word", oi[0], 32'hB02C_0003);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1000 || i == 2000) do_reset();
      cycle($urandom_range(0, 15) == 0,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
